// File: rtl/iterative_left_shifter_if.sv
// Request/response bundle for the iterative left shifter: operands and
// START in, registered OUTPUT with BUSY/DONE status out.
interface iterative_left_shifter_if #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 8
);
   // Handshake: START is a level sampled only while the unit is idle
   // (BUSY=0, DONE=0); operands are captured on that same edge. BUSY is
   // high for every cycle of the shift, DONE pulses for exactly one cycle
   // when OUTPUT has just been updated. No backpressure on the result side.
   logic             START;
   logic [WIDTH-1:0] DATA1;
   logic [AMT_W-1:0] DATA2;
   logic [1:0]       SETPIN;
   logic [WIDTH-1:0] OUTPUT;
   logic             BUSY;
   logic             DONE;

   modport master (
      output START, DATA1, DATA2, SETPIN,
      input  OUTPUT, BUSY, DONE
   );

   modport slave (
      input  START, DATA1, DATA2, SETPIN,
      output OUTPUT, BUSY, DONE
   );
endinterface

// File: rtl/iterative_left_shifter.sv
// One-bit-per-clock left shift / rotate unit (SLL and ROL) with START/BUSY/DONE.
// Build option LSHIFT_NIBBLE_STEP_EN: shift by 4 per clock while 4+ bits remain.
module iterative_left_shifter #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 8
) (
   input  logic                    CLK,
   input  logic                    RESET,
   iterative_left_shifter_if.slave bus,
   output logic [1:0]              state_dbg
);

   localparam int LOG2 = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FIN   = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [LOG2-1:0]  cnt;
   logic             op_rol;
   logic [WIDTH-1:0] result;
   logic             busy;
   logic             done;

   // Request decode, valid only in IDLE while START is high.
   logic             req_rol;
   logic             req_ovf;
   logic [LOG2-1:0]  req_n;
   logic [WIDTH-1:0] req_load;

   // SETPIN[0] carries no meaning for this unit.
   logic unused_setpin;
   assign unused_setpin = bus.SETPIN[0];

   always_comb begin
      req_rol  = ~bus.SETPIN[1];
      req_ovf  = |(bus.DATA2 >> LOG2);
      req_n    = bus.DATA2[LOG2-1:0];
      req_load = bus.DATA1;
      // A logical shift by WIDTH or more empties the register outright.
      if (!req_rol && req_ovf) begin
         req_n    = '0;
         req_load = '0;
      end
   end

   // Next shift-register value and the count consumed by this step.
   logic [WIDTH-1:0] shift_next;
   logic [LOG2-1:0]  step_amt;
   logic             last_step;

`ifdef LSHIFT_NIBBLE_STEP_EN
   logic nibble_step;

   always_comb begin
      nibble_step = (cnt >= LOG2'(4));
      step_amt    = nibble_step ? LOG2'(4) : LOG2'(1);
      if (nibble_step) begin
         shift_next = op_rol ? {shreg[WIDTH-5:0], shreg[WIDTH-1:WIDTH-4]}
                             : {shreg[WIDTH-5:0], 4'b0000};
      end else begin
         shift_next = op_rol ? {shreg[WIDTH-2:0], shreg[WIDTH-1]}
                             : {shreg[WIDTH-2:0], 1'b0};
      end
      last_step = (cnt == step_amt);
   end
`else
   always_comb begin
      step_amt   = LOG2'(1);
      shift_next = op_rol ? {shreg[WIDTH-2:0], shreg[WIDTH-1]}
                          : {shreg[WIDTH-2:0], 1'b0};
      last_step  = (cnt == LOG2'(1));
   end
`endif

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state  <= IDLE;
         shreg  <= '0;
         cnt    <= '0;
         op_rol <= 1'b0;
         result <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               busy <= 1'b0;
               if (bus.START) begin
                  shreg  <= req_load;
                  op_rol <= req_rol;
                  cnt    <= req_n;
                  if (req_n != '0) begin
                     state <= SHIFT;
                     busy  <= 1'b1;
                  end else begin
                     // Nothing to shift: the loaded value is the answer.
                     state  <= FIN;
                     result <= req_load;
                     done   <= 1'b1;
                  end
               end
            end

            SHIFT: begin
               shreg <= shift_next;
               cnt   <= cnt - step_amt;
               if (last_step) begin
                  state  <= FIN;
                  result <= shift_next;
                  busy   <= 1'b0;
                  done   <= 1'b1;
               end
            end

            FIN: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.OUTPUT = result;
   assign bus.BUSY   = busy;
   assign bus.DONE   = done;
   assign state_dbg  = state;

endmodule

// File: tb/tb_iterative_left_shifter.sv
// Scoreboard bench for iterative_left_shifter: directed vectors push expected
// result/latency/busy counts, a negedge monitor pops and compares on DONE.
module tb_iterative_left_shifter;

   logic       CLK;
   logic       RESET;
   logic [1:0] state_dbg;

   iterative_left_shifter_if #(.WIDTH(8), .AMT_W(8)) bus ();

   iterative_left_shifter #(.WIDTH(8), .AMT_W(8)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // Clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc++;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Edges spent in SHIFT for a count of n.
   function automatic int lat_of(input int n);
`ifdef LSHIFT_NIBBLE_STEP_EN
      return n / 4 + n % 4;
`else
      return n;
`endif
   endfunction

   // Scoreboard
   logic [7:0] exp_q[$];
   int         exp_done_cyc_q[$];
   int         exp_busy_q[$];
   logic [7:0] hold_val = 8'h00;
   int         busy_cnt = 0;
   int         done_cnt = 0;

   always @(negedge CLK) begin
      if (!RESET) begin
         busy_cnt = 0;
      end else begin
         if (bus.BUSY) begin
            busy_cnt++;
            check("output_hold_while_busy", 32'(bus.OUTPUT), 32'(hold_val));
         end
         if (bus.DONE) begin
            done_cnt++;
            check("done_without_busy", 32'(bus.BUSY), 32'd0);
            if (exp_q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               logic [7:0] e;
               int         dc;
               int         bc;
               e  = exp_q.pop_front();
               dc = exp_done_cyc_q.pop_front();
               bc = exp_busy_q.pop_front();
               check("result", 32'(bus.OUTPUT), 32'(e));
               check("done_latency_cycle", 32'(cyc), 32'(dc));
               check("busy_cycles", 32'(busy_cnt), 32'(bc));
               hold_val = e;
            end
            busy_cnt = 0;
         end
      end
   end

   // Driver tasks
   task automatic issue(input logic [1:0] sp, input logic [7:0] d1, input logic [7:0] d2,
                        input logic [7:0] exp_out, input int n, input bit expect_done);
      @(posedge CLK);
      #1;
      bus.SETPIN = sp;
      bus.DATA1  = d1;
      bus.DATA2  = d2;
      bus.START  = 1'b1;
      @(posedge CLK);
      #1;
      bus.START  = 1'b0;
      // Scramble operands after the sampling edge.
      bus.SETPIN = ~sp;
      bus.DATA1  = ~d1;
      bus.DATA2  = d2 + 8'd3;
      if (expect_done) begin
         exp_q.push_back(exp_out);
         exp_done_cyc_q.push_back(cyc + lat_of(n));
         exp_busy_q.push_back(lat_of(n));
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge CLK);
      if (exp_q.size() != 0) begin
         check("drain_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
         exp_done_cyc_q.delete();
         exp_busy_q.delete();
      end
   endtask

   task automatic run(input logic [1:0] sp, input logic [7:0] d1, input logic [7:0] d2,
                      input logic [7:0] exp_out, input int n);
      issue(sp, d1, d2, exp_out, n, 1'b1);
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "global timeout");
   end

   initial begin
      int dc_before;
      RESET      = 1'b0;
      bus.START  = 1'b0;
      bus.DATA1  = 8'h00;
      bus.DATA2  = 8'h00;
      bus.SETPIN = 2'b00;
      #3;
      check("reset_output", 32'(bus.OUTPUT), 32'h0);
      check("reset_busy", 32'(bus.BUSY), 32'h0);
      check("reset_done", 32'(bus.DONE), 32'h0);
      check("reset_state", 32'(state_dbg), 32'h0);
      repeat (3) @(posedge CLK);
      #1 RESET = 1'b1;

      // SETPIN: 2'b0x = ROL, 2'b1x = SLL
      run(2'b00, 8'h96, 8'd3,   8'hB4, 3);
      run(2'b10, 8'h81, 8'd1,   8'h02, 1);
      run(2'b10, 8'hFF, 8'd9,   8'h00, 0);
      run(2'b00, 8'h5A, 8'd10,  8'h69, 2);
      run(2'b00, 8'h3C, 8'd0,   8'h3C, 0);
      run(2'b10, 8'h3C, 8'd0,   8'h3C, 0);
      run(2'b10, 8'h01, 8'd6,   8'h40, 6);
      run(2'b10, 8'hA5, 8'd8,   8'h00, 0);
      run(2'b00, 8'hA5, 8'd8,   8'hA5, 0);
      run(2'b10, 8'hFF, 8'd7,   8'h80, 7);
      run(2'b00, 8'h12, 8'd4,   8'h21, 4);
      run(2'b00, 8'hC3, 8'd255, 8'hE1, 7);
      run(2'b01, 8'h0F, 8'd1,   8'h1E, 1);
      run(2'b11, 8'h0F, 8'd2,   8'h3C, 2);
      run(2'b10, 8'hFF, 8'd200, 8'h00, 0);

      // START during SHIFT must be ignored.
      issue(2'b00, 8'h01, 8'd7, 8'h80, 7, 1'b1);
      @(posedge CLK);
      @(posedge CLK);
      #1;
      bus.SETPIN = 2'b10;
      bus.DATA1  = 8'hFF;
      bus.DATA2  = 8'd1;
      bus.START  = 1'b1;
      @(posedge CLK);
      #1 bus.START = 1'b0;
      drain();
      dc_before = done_cnt;
      repeat (6) @(negedge CLK);
      check("no_extra_done_after_ignored_start", 32'(done_cnt), 32'(dc_before));
      check("idle_busy_after_ignored_start", 32'(bus.BUSY), 32'h0);
      check("output_after_ignored_start", 32'(bus.OUTPUT), 32'h80);

      // Reset mid-operation aborts with no DONE.
      issue(2'b10, 8'hF0, 8'd5, 8'h00, 5, 1'b0);
      @(posedge CLK);
      #1 RESET = 1'b0;
      #1;
      check("abort_output", 32'(bus.OUTPUT), 32'h0);
      check("abort_busy", 32'(bus.BUSY), 32'h0);
      check("abort_done", 32'(bus.DONE), 32'h0);
      check("abort_state", 32'(state_dbg), 32'h0);
      hold_val = 8'h00;
      @(posedge CLK);
      @(posedge CLK);
      #1 RESET = 1'b1;
      dc_before = done_cnt;
      repeat (10) @(negedge CLK);
      check("no_done_after_abort", 32'(done_cnt), 32'(dc_before));
      check("idle_output_after_abort", 32'(bus.OUTPUT), 32'h0);

      run(2'b00, 8'h96, 8'd3, 8'hB4, 3);
      repeat (3) @(negedge CLK);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/iterative_left_shifter.md
Name: iterative_left_shifter

Overview:
- Multi-cycle left shift/rotate unit for the 8-bit ALU datapath; the left-direction counterpart of the combinational right shifter.
- Performs one bit of shift per clock under a START/BUSY/DONE handshake, trading latency for area.
- Sits beside the ALU functional units. The control unit stalls the PC on BUSY and captures OUTPUT on DONE.

Parameters:
- WIDTH, 8, operand/result width in bits; amount decode assumes a power of two.
- AMT_W, 8, width of the shift-amount input DATA2.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-low reset; clears all state immediately when low.
- START  input  1  request; sampled only in IDLE.
- DATA1  input  WIDTH  operand to shift; sampled with START.
- DATA2  input  AMT_W  unsigned shift amount; sampled with START.
- SETPIN  input  2  operation select; sampled with START. SETPIN[1]=0 selects ROL, SETPIN[1]=1 selects SLL. SETPIN[0] is ignored.
- OUTPUT  output  WIDTH  registered result; holds its value until the next completion.
- BUSY  output  1  high while a shift is in progress.
- DONE  output  1  single-cycle completion pulse.

Behaviour:
- Reset (RESET low, async): state=IDLE, OUTPUT=0, BUSY=0, DONE=0, internal shift register=0, counter=0. Reset mid-operation aborts the operation; no DONE is issued.
- FSM states: IDLE, SHIFT, FIN.
- IDLE: BUSY=0, DONE=0. On a rising edge with START=1:
  - shreg <= DATA1.
  - Count n is decoded as follows. ROL: n = DATA2 mod WIDTH (low log2(WIDTH) bits). SLL with DATA2 < WIDTH: n = DATA2. SLL with DATA2 >= WIDTH: n=0 and shreg <= 0.
  - If n != 0: go to SHIFT with cnt=n.
  - If n == 0: go to FIN, and OUTPUT <= loaded value (DATA1, or 0 for an SLL overflow).
- SHIFT: BUSY=1, DONE=0. Each edge updates shreg:
  - SLL: shreg <= {shreg[WIDTH-2:0], 0}.
  - ROL: shreg <= {shreg[WIDTH-2:0], shreg[WIDTH-1]}.
  - cnt decrements by 1 on each edge.
  - On the edge where cnt==1: OUTPUT <= the shifted value, then go to FIN.
- FIN: BUSY=0, DONE=1 for exactly one cycle; unconditionally returns to IDLE.
- Latency: START is sampled at edge k. DONE is high in the cycle after edge k+n. Total is n+1 cycles (1 cycle when n=0).
- START while in SHIFT or FIN is ignored: no queuing, no effect on the operation in flight. Back-to-back operations need START in the first IDLE cycle after DONE.
- DATA1, DATA2 and SETPIN may change freely after the START edge; the operation uses the sampled values only.
- OUTPUT changes only on entry to FIN and is otherwise stable, including while BUSY.

Optional Feature:
- Macro: LSHIFT_NIBBLE_STEP_EN.
- Defined: in SHIFT, when cnt >= 4 a single edge shifts/rotates by 4 and cnt decrements by 4; otherwise the step is 1 bit. Latency becomes floor(n/4) + (n mod 4) + 1 cycles. Results are bit-identical to the non-macro build.
- Not defined: the step is always 1 bit, with latency n+1 as specified above. No nibble-step logic is present.

Test Plan:
- ROL, DATA1=0x96, DATA2=3, START one cycle -> BUSY high 3 cycles, DONE pulse in the 4th cycle after the START edge, OUTPUT=0xB4.
- SLL, DATA1=0x81, DATA2=1 -> OUTPUT=0x02, DONE 2 cycles after the START edge.
- SLL, DATA1=0xFF, DATA2=9 -> no SHIFT state entered, OUTPUT=0x00, DONE 1 cycle after START. Also ROL, DATA1=0x5A, DATA2=10 -> OUTPUT=0x69 after 3 cycles (amount mod 8 = 2).
- DATA2=0 (both ops), DATA1=0x3C -> OUTPUT=0x3C, DONE the next cycle, BUSY never high.
- Start ROL 0x01 by 7. Pulse START with new operands at cycle 3 -> ignored, OUTPUT=0x80 at DONE. Next, start SLL 0xF0 by 5 and drive RESET low at cycle 2 -> OUTPUT/BUSY/DONE go to 0 immediately, no DONE pulse after release.
- With LSHIFT_NIBBLE_STEP_EN: SLL, DATA1=0x01, DATA2=6 -> OUTPUT=0x40, DONE 4 cycles after START (1 nibble step + 2 single steps + 1).
